adder_sum_accumulator: RTL
==========================

// Module: adder_sum_accumulator
// PURPOSE
//  Downstream stage of the adder: consumes the registered adder sum stream and
//  accumulates FRAME_LEN qualified sums into one frame total. Totals are
//  presented on a valid/ready output port.
//  Double-buffered: the next frame accumulates while the previous total waits.
//  Unsigned arithmetic, saturating accumulator, sticky overrun flag.
// PARAMETERS
//  DATA_W     8   adder operand width; incoming sum is DATA_W+1 bits
//  ACC_W      16  accumulator/output width (>= DATA_W+1)
//  FRAME_LEN  8   sums per frame (>= 1); counter width $clog2(FRAME_LEN+1)
// PORTS
//  clk_i        in   1         single clock, rising edge
//  rst_n_i      in   1         asynchronous, active-low reset
//  clear_i      in   1         sync clear: drop partial frame, output reg, flags
//  sum_valid_i  in   1         sum_i qualified this cycle (no backpressure upstream)
//  sum_i        in   DATA_W+1  adder sum, unsigned
//  acc_valid_o  out  1         frame total available
//  acc_ready_i  in   1         consumer accepts total when valid&ready
//  acc_data_o   out  ACC_W     frame total (saturated)
//  acc_sat_o    out  1         total saturated; qualified by acc_valid_o
//  overrun_o    out  1         sticky: a completed frame was discarded
//  frame_cnt_o  out  cnt_w     sums accumulated in the current frame
// BEHAVIOUR
//  Reset (async assert, sync deassert): all outputs 0, acc reg 0, count 0, FSM ACCUM.
//  FSM: ACCUM (count < FRAME_LEN-1) -> LAST (count == FRAME_LEN-1) -> ACCUM.
//   FRAME_LEN==1: permanently LAST.
//  - Sample: on sum_valid_i, acc <= sat(acc + zext(sum_i)), count++.
//   sat clamps to 2**ACC_W-1 and sets frame sat bit.
//  - Completion: sum_valid_i in LAST. The total includes that sum. Next cycle:
//   acc_valid_o=1, acc_data_o=total, acc_sat_o=frame sat bit.
//   acc, count and sat bit clear in the same edge; next frame starts with no gap.
//  - Output reg holds data/sat stable while valid & !ready.
//   valid drops the cycle after accept unless reloaded.
//  - Completion while output reg full and acc_ready_i=0: new total discarded,
//   output reg unchanged, overrun_o<=1 (sticky until clear_i/reset).
//  - Completion in the same cycle as accept (valid&ready): new total loads.
//   acc_valid_o stays 1. No overrun.
//  - sum_valid_i=0 cycles: state holds. Gaps anywhere in a frame are legal.
//  - clear_i has priority over a same-cycle sample/completion.
//   Next cycle: count=0, acc_valid_o=0, overrun_o=0.
//  - Reset mid-frame: partial frame and pending total lost. No output after release.
//  - Latency: last sum of frame -> acc_valid_o is 1 cycle. Throughput: 1 sum/cycle.
// STRUCTURE
//  adder_pkg: DATA_W default, typedef sum_t [DATA_W:0], typedef acc_t [ACC_W-1:0],
//   enum acc_state_e {ACC_ACCUM, ACC_LAST}, function sat_add(acc_t, sum_t).
//  Sub-module adder_result_reg: one-entry valid/ready holding register
//   (load, data, sat in; valid/data/sat out; reports overrun on blocked load).
//  Top: counter + FSM + saturating accumulate + adder_result_reg instance.
// TESTING (DATA_W=8, ACC_W=10, FRAME_LEN=4 unless noted)
//  1 sums 1,2,3,4 on consecutive cycles, ready=1
//    -> acc_valid_o 1 cycle after the 4th, acc_data_o=10, acc_sat_o=0, 1-cycle pulse.
//  2 sums 5,_,6,_,_,7,8 (gaps) -> total 26 one cycle after 8.
//    frame_cnt_o tracks 1,1,2,2,2,3 then 0.
//  3 sums 510,510,510,510 -> acc_data_o=1023, acc_sat_o=1.
//    Next frame 1,1,1,1 -> 4, sat 0.
//  4 ready=0, frames {1,1,1,1} then {2,2,2,2} -> output holds 4, overrun_o=1.
//    ready=1 -> 4 accepted, valid drops. 8 never appears.
//  5 ready=0 with frame A=4 pending; ready=1 exactly on frame B's completion cycle
//    -> A accepted, B=8 valid next cycle, overrun_o=0.
//  6 rst_n_i low after 2 samples of a frame, and separately clear_i with a pending total
//    -> all outputs 0. Next 4 sums yield their own total only.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder result path.
// Holds default widths, the accumulator state enum and the saturating add.
package adder_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_FRAME_LEN = 8;

    typedef logic [DEF_DATA_W:0]    sum_t;
    typedef logic [DEF_ACC_W-1:0]   acc_t;

    typedef enum logic {
        ACC_ACCUM = 1'b0,
        ACC_LAST  = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } sat_res_t;

    // Width-generic so any ACC_W up to 32 can share one helper.
    function automatic sat_res_t sat_add(
        input logic [31:0] acc,
        input logic [31:0] sum,
        input int unsigned width
    );
        logic [32:0] wide;
        logic [32:0] lim;
        sat_res_t    res;
        wide    = {1'b0, acc} + {1'b0, sum};
        lim     = (33'd1 << width) - 33'd1;
        res.sat = (wide > lim);
        res.val = res.sat ? lim[31:0] : wide[31:0];
        return res;
    endfunction

endpackage

// File: rtl/adder_result_reg.sv
// One-entry valid/ready holding register for completed frame totals.
// A load while full and not being drained is dropped and flagged.
import adder_pkg::*;

module adder_result_reg #(
    parameter int W = DEF_ACC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_sat,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         sat,
    output logic         overrun
);

    logic accept;

    assign accept = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            data    <= '0;
            sat     <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            data    <= '0;
            sat     <= 1'b0;
            overrun <= 1'b0;
        end else if (load) begin
            if (valid && !ready) begin
                overrun <= 1'b1;
            end else begin
                valid <= 1'b1;
                data  <= load_data;
                sat   <= load_sat;
            end
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Frame accumulator for the adder sum stream.
// Sums FRAME_LEN qualified samples, saturating, into a double-buffered total.
import adder_pkg::*;

module adder_sum_accumulator #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              sum_valid_i,
    input  logic [DATA_W:0]   sum_i,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic [ACC_W-1:0]  acc_data_o,
    output logic              acc_sat_o,
    output logic              overrun_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam acc_state_e START = (FRAME_LEN == 1) ? ACC_LAST : ACC_ACCUM;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_q;
    acc_state_e       state_q;

    sat_res_t         add;
    logic [ACC_W-1:0] total;
    logic             total_sat;
    logic             done;
    logic             unused_hi;

    always_comb begin
        add       = sat_add(32'(acc_q), 32'(sum_i), unsigned'(ACC_W));
        total     = add.val[ACC_W-1:0];
        total_sat = sat_q | add.sat;
        done      = sum_valid_i && (state_q == ACC_LAST) && !clear_i;
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    assign unused_hi = ^(add.val >> ACC_W);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= START;
        end else if (clear_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= START;
        end else if (sum_valid_i) begin
            if (state_q == ACC_LAST) begin
                // Total leaves via the result register; next frame starts now.
                acc_q   <= '0;
                cnt_q   <= '0;
                sat_q   <= 1'b0;
                state_q <= START;
            end else begin
                acc_q   <= total;
                sat_q   <= total_sat;
                cnt_q   <= cnt_inc;
                state_q <= (cnt_inc == LAST_CNT) ? ACC_LAST : ACC_ACCUM;
            end
        end
    end

    assign frame_cnt_o = cnt_q;

    adder_result_reg #(
        .W(ACC_W)
    ) u_result (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clear     (clear_i),
        .load      (done),
        .load_data (total),
        .load_sat  (total_sat),
        .ready     (acc_ready_i),
        .valid     (acc_valid_o),
        .data      (acc_data_o),
        .sat       (acc_sat_o),
        .overrun   (overrun_o)
    );

endmodule
